// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the MEM-stage load/store unit.
// funct3 encodings, LSU state encoding, request struct and the
// store-lane / alignment helper functions.
package rv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Latched access attributes needed after the request leaves IDLE.
  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] off;
  } lsu_req_t;

  // funct3[1:0]: 00 byte, 01 half, 1x word (reserved codes fall into word).
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Right-justified store data replicated across every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/ready data bus between the LSU (master) and memory (slave).
interface mem_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half of a bus word and
// sign- or zero-extends it according to funct3. Purely combinational.
module lsu_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Lane select then extension; reserved codes return the whole word.
  always_comb begin
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'b0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'b0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Converts memReadM/memWriteM into a
// req/ready bus transaction, stalls the pipeline until it completes (or
// times out) and delivers formatted load data in readDataM.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds misalignM, traps
// misaligned half/word accesses without touching the bus).
module mem_lsu
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        busErrM,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalignM,
`endif
  mem_lsu_if.master   bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e    state;
  logic [CW-1:0] cnt;
  lsu_req_t      req_q;
  logic [31:0]   load_fmt;
  logic          access;
  logic          is_store;

  // A simultaneous read+write is treated as a load.
  assign access   = memReadM | memWriteM;
  assign is_store = memWriteM & ~memReadM;

  // Stall covers the detect cycle and every BUSY cycle; DONE lets the pipe move.
  assign stallM = reset_n & (((state == LSU_IDLE) & access) | (state == LSU_BUSY));

  lsu_load_align u_align (
    .rdata  (bus.bus_rdata),
    .off    (req_q.off),
    .funct3 (req_q.f3),
    .data   (load_fmt)
  );

  // Access FSM: latch request in IDLE, wait for ready/timeout in BUSY, release in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= LSU_IDLE;
      cnt           <= '0;
      req_q         <= '0;
      readDataM     <= '0;
      busErrM       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wstrb <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalignM     <= 1'b0;
`endif
    end else begin
      busErrM <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalignM <= 1'b0;
`endif
      case (state)
        LSU_IDLE: begin
          if (access) begin
            req_q <= '{f3: funct3M, off: ALUresultM[1:0]};
            cnt   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned(funct3M, ALUresultM[1:0])) begin
              misalignM <= 1'b1;
              readDataM <= '0;
              state     <= LSU_DONE;
            end else
`endif
            begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= is_store;
              bus.bus_addr  <= {ALUresultM[31:2], 2'b00};
              bus.bus_wdata <= is_store ? store_wdata(funct3M, writeDataM) : '0;
              bus.bus_wstrb <= is_store ? store_strb(funct3M, ALUresultM[1:0]) : 4'b0000;
              state         <= LSU_BUSY;
            end
          end
        end
        LSU_BUSY: begin
          // Ready on the final allowed cycle still completes without error.
          if (bus.bus_ready) begin
            bus.bus_req <= 1'b0;
            readDataM   <= bus.bus_we ? '0 : load_fmt;
            state       <= LSU_DONE;
          end else if (cnt == CNT_LAST) begin
            bus.bus_req <= 1'b0;
            readDataM   <= '0;
            busErrM     <= 1'b1;
            state       <= LSU_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu (TIMEOUT_CYCLES=4).
// Expected load results go into a scoreboard queue when an access is
// driven and are popped when the LSU reaches its DONE cycle.
module tb_mem_lsu;
  import rv_mem_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        memReadM, memWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUresultM, writeDataM;
  logic [31:0] readDataM;
  logic        stallM, busErrM;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalignM;
`endif

  mem_lsu_if bus();

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .memReadM   (memReadM),
    .memWriteM  (memWriteM),
    .funct3M    (funct3M),
    .ALUresultM (ALUresultM),
    .writeDataM (writeDataM),
    .readDataM  (readDataM),
    .stallM     (stallM),
    .busErrM    (busErrM),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalignM  (misalignM),
`endif
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access. ready_after = BUSY cycle index that sees bus_ready (<0: never).
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ready_after, input logic [31:0] exp_rd, input int exp_stall,
                        input logic exp_err, input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    int  stalls;
    bit  done;
    logic [31:0] exp_v;
    memReadM = rd; memWriteM = wr; funct3M = f3; ALUresultM = addr; writeDataM = wd;
    exp_q.push_back(exp_rd);
    stalls = 0;
    done   = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clock);
      if (stallM) begin
        stalls++;
        if (bus.bus_req) begin
          if (stalls == 2) begin
            check({tag, " addr"}, bus.bus_addr, {addr[31:2], 2'b00});
            check({tag, " we"},   32'(bus.bus_we), 32'(wr & ~rd));
            check({tag, " strb"}, 32'(bus.bus_wstrb), 32'(exp_strb));
            if (wr && !rd) check({tag, " wdata"}, bus.bus_wdata, exp_wdata);
          end
          if (stalls - 1 == ready_after) begin
            bus.bus_ready = 1'b1;
            bus.bus_rdata = rdat;
          end
        end
      end else begin
        done  = 1;
        exp_v = exp_q.pop_front();
        check({tag, " stall"},  32'(stalls), 32'(exp_stall));
        check({tag, " rdata"},  readDataM, exp_v);
        check({tag, " err"},    32'(busErrM), 32'(exp_err));
        check({tag, " reqoff"}, 32'(bus.bus_req), 32'd0);
      end
      @(posedge clock); #1;
      bus.bus_ready = 1'b0;
      bus.bus_rdata = $urandom;
    end
    if (!done) check({tag, " done_timeout"}, 32'(done), 32'd1);
    memReadM = 1'b0; memWriteM = 1'b0;
    @(negedge clock);
    check({tag, " idle_stall"}, 32'(stallM), 32'd0);
    check({tag, " err_pulse"},  32'(busErrM), 32'd0);
    check({tag, " hold"},       readDataM, exp_rd);
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    memReadM = 1'b1; memWriteM = 1'b0; funct3M = F3_LW;
    ALUresultM = 32'h100; writeDataM = '0;
    bus.bus_ready = 1'b0; bus.bus_rdata = '0;

    // Reset state, with a load request already presented.
    @(negedge clock);
    check("rst stall", 32'(stallM), 32'd0);
    check("rst req",   32'(bus.bus_req), 32'd0);
    check("rst err",   32'(busErrM), 32'd0);
    check("rst rdata", readDataM, 32'd0);
    check("rst addr",  bus.bus_addr, 32'd0);
    check("rst strb",  32'(bus.bus_wstrb), 32'd0);
    memReadM = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    //      tag      rd wr f3       addr         wdata         rdata          rdy result        st err strb     wdata
    access("lw",     1, 0, F3_LW,  32'h100, 32'h0,        32'hDEADBEEF, 2,  32'hDEADBEEF, 3, 0, 4'b0000, 32'h0);
    access("lb",     1, 0, F3_LB,  32'h103, 32'h0,        32'h80112233, 1,  32'hFFFFFF80, 2, 0, 4'b0000, 32'h0);
    access("lbu",    1, 0, F3_LBU, 32'h103, 32'h0,        32'h80112233, 1,  32'h00000080, 2, 0, 4'b0000, 32'h0);
    access("lh",     1, 0, F3_LH,  32'h102, 32'h0,        32'h80112233, 3,  32'hFFFF8011, 4, 0, 4'b0000, 32'h0);
    access("lhu",    1, 0, F3_LHU, 32'h100, 32'h0,        32'h8011A233, 1,  32'h0000A233, 2, 0, 4'b0000, 32'h0);
    access("lb1",    1, 0, F3_LB,  32'h101, 32'h0,        32'h80112233, 1,  32'h00000022, 2, 0, 4'b0000, 32'h0);
    access("sb",     0, 1, F3_SB,  32'h201, 32'h000000A5, 32'h12345678, 1,  32'h0,        2, 0, 4'b0010, 32'hA5A5A5A5);
    access("sh",     0, 1, F3_SH,  32'h202, 32'hFFFF1234, 32'h12345678, 2,  32'h0,        3, 0, 4'b1100, 32'h12341234);
    access("sw",     0, 1, F3_SW,  32'h204, 32'hCAFEF00D, 32'h12345678, 1,  32'h0,        2, 0, 4'b1111, 32'hCAFEF00D);
    access("rsvd",   1, 0, 3'b111, 32'h208, 32'h0,        32'h0BADF00D, 1,  32'h0BADF00D, 2, 0, 4'b0000, 32'h0);
    access("tmo",    1, 0, F3_LW,  32'h300, 32'h0,        32'h55555555, -1, 32'h0,        5, 1, 4'b0000, 32'h0);
    access("lastrdy",1, 0, F3_LW,  32'h304, 32'h0,        32'h600DCAFE, 4,  32'h600DCAFE, 5, 0, 4'b0000, 32'h0);
    access("rdwr",   1, 1, F3_LW,  32'h500, 32'hFFFFFFFF, 32'h13579BDF, 1,  32'h13579BDF, 2, 0, 4'b0000, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned word traps without reaching the bus.
    memReadM = 1'b1; funct3M = F3_LW; ALUresultM = 32'h102;
    @(negedge clock);
    check("mis stall", 32'(stallM), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("mis req",   32'(bus.bus_req), 32'd0);
    check("mis pulse", 32'(misalignM), 32'd1);
    check("mis stall2", 32'(stallM), 32'd0);
    check("mis rdata", readDataM, 32'd0);
    @(posedge clock); #1;
    memReadM = 1'b0;
`else
    access("lwmis",  1, 0, F3_LW,  32'h102, 32'h0,        32'hA1B2C3D4, 1,  32'hA1B2C3D4, 2, 0, 4'b0000, 32'h0);
`endif

    // Reset while BUSY abandons the transaction at once.
    memReadM = 1'b1; funct3M = F3_LW; ALUresultM = 32'h400;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    check("mid busy req", 32'(bus.bus_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid rst req",   32'(bus.bus_req), 32'd0);
    check("mid rst stall", 32'(stallM), 32'd0);
    @(posedge clock); #1;
    memReadM = 1'b0;
    reset_n  = 1'b1;
    @(posedge clock); #1;
    access("post",   1, 0, F3_LHU, 32'h402, 32'h0,        32'hBEEF0000, 2,  32'h0000BEEF, 3, 0, 4'b0000, 32'h0);

    check("sb empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
